// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: light codes, directions, phase states.
package traffic_pkg;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] GREEN  = 2'b10;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef enum logic [2:0] {
    StAllRed,
    StNsGreen,
    StNsYellow,
    StEwGreen,
    StEwYellow,
    StWalk,
    StEmg
  } phase_e;

  function automatic phase_e green_of(input logic dir);
    return (dir == DIR_EW) ? StEwGreen : StNsGreen;
  endfunction

  function automatic phase_e yellow_of(input logic dir);
    return (dir == DIR_EW) ? StEwYellow : StNsYellow;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: clears when the phase changes, saturates at all-ones, flags the terminal count.
module phase_timer #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] last,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: restart on a phase change, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ">=" lets a saturated green count keep reporting that its minimum has elapsed.
  assign done = (cnt_q >= last);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase scheduler with pedestrian walk and emergency preemption.
module intersection_phase_scheduler #(
  parameter int unsigned MIN_GREEN = 8,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 2,
  parameter int unsigned WALK      = 6,
  parameter int unsigned CNT_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_ns,
  input  logic       req_ew,
  input  logic       ped_req,
  input  logic       emergency,
  input  logic       emg_dir,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic       walk,
  output logic       emergency_active,
  output logic       ped_pending
);
  import traffic_pkg::*;

  localparam logic [CNT_W-1:0] GreenLast  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YellowLast = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] AllRedLast = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WalkLast   = CNT_W'(WALK - 1);

  phase_e state_q, state_d;
  logic pend_ns_q, pend_ns_d;
  logic pend_ew_q, pend_ew_d;
  logic pend_ped_q, pend_ped_d;
  logic last_dir_q, last_dir_d;
  logic emg_dir_q, emg_dir_d;
  logic served_q, served_d;
  logic [1:0] ns_light_q, ns_light_d;
  logic [1:0] ew_light_q, ew_light_d;
  logic walk_q, walk_d;
  logic emg_act_q, emg_act_d;

  logic [CNT_W-1:0] last;
  logic done;
  logic state_change;
  logic opp_pend, same_pend, idle_dir;
  logic ns_green_now, ew_green_now;

  assign state_change = (state_d != state_q);

  phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state_change),
    .last (last),
    .done (done)
  );

  // Terminal count for the current phase; EMG never times out.
  always_comb begin
    last = AllRedLast;
    unique case (state_q)
      StNsGreen, StEwGreen:   last = GreenLast;
      StNsYellow, StEwYellow: last = YellowLast;
      StAllRed:               last = AllRedLast;
      StWalk:                 last = WalkLast;
      StEmg:                  last = '1;
      default:                last = AllRedLast;
    endcase
  end

  assign opp_pend  = (last_dir_q == DIR_EW) ? pend_ns_q : pend_ew_q;
  assign same_pend = (last_dir_q == DIR_EW) ? pend_ew_q : pend_ns_q;
  // Until any green has been granted, an idle intersection starts on NS.
  assign idle_dir  = served_q ? last_dir_q : DIR_NS;

  // Phase sequencing.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAllRed: begin
        if (done) begin
          if (emergency)      state_d = StEmg;
          else if (pend_ped_q) state_d = StWalk;
          else if (opp_pend)  state_d = green_of(~last_dir_q);
          else if (same_pend) state_d = green_of(last_dir_q);
          else                state_d = green_of(idle_dir);
        end
      end
      StNsGreen: begin
        if (emergency) begin
          state_d = (emg_dir == DIR_NS) ? StEmg : StNsYellow;
        end else if (done && (pend_ew_q || pend_ped_q)) begin
          state_d = StNsYellow;
        end
      end
      StEwGreen: begin
        if (emergency) begin
          state_d = (emg_dir == DIR_EW) ? StEmg : StEwYellow;
        end else if (done && (pend_ns_q || pend_ped_q)) begin
          state_d = StEwYellow;
        end
      end
      StNsYellow, StEwYellow: begin
        if (done) state_d = StAllRed;
      end
      StWalk: begin
        if (emergency || done) state_d = StAllRed;
      end
      StEmg: begin
        if (!emergency) state_d = yellow_of(emg_dir_q);
      end
      default: state_d = StAllRed;
    endcase
  end

  assign ns_green_now = (state_q == StNsGreen) || ((state_q == StEmg) && (emg_dir_q == DIR_NS));
  assign ew_green_now = (state_q == StEwGreen) || ((state_q == StEmg) && (emg_dir_q == DIR_EW));

  // Request latches, direction history and emergency direction latch.
  always_comb begin
    pend_ns_d  = pend_ns_q;
    pend_ew_d  = pend_ew_q;
    pend_ped_d = pend_ped_q;
    last_dir_d = last_dir_q;
    emg_dir_d  = emg_dir_q;
    served_d   = served_q;

    if (state_change && (state_d == StNsGreen)) pend_ns_d = 1'b0;
    else if (req_ns && !ns_green_now)            pend_ns_d = 1'b1;

    if (state_change && (state_d == StEwGreen)) pend_ew_d = 1'b0;
    else if (req_ew && !ew_green_now)            pend_ew_d = 1'b1;

    // A walk cut short by an emergency is still owed to the pedestrian.
    if (state_change && (state_d == StWalk)) begin
      pend_ped_d = 1'b0;
    end else if (ped_req || ((state_q == StWalk) && state_change && !done)) begin
      pend_ped_d = 1'b1;
    end

    if (state_change && (state_d == StNsGreen)) begin
      last_dir_d = DIR_NS;
      served_d   = 1'b1;
    end else if (state_change && (state_d == StEwGreen)) begin
      last_dir_d = DIR_EW;
      served_d   = 1'b1;
    end else if ((state_q == StEmg) && state_change) begin
      last_dir_d = emg_dir_q;
    end

    if (state_change && (state_d == StEmg)) emg_dir_d = emg_dir;
  end

  // Moore output decode from the next state so the registered outputs change with the state.
  always_comb begin
    ns_light_d = traffic_pkg::RED;
    ew_light_d = traffic_pkg::RED;
    walk_d     = 1'b0;
    emg_act_d  = 1'b0;
    unique case (state_d)
      StNsGreen:  ns_light_d = traffic_pkg::GREEN;
      StNsYellow: ns_light_d = traffic_pkg::YELLOW;
      StEwGreen:  ew_light_d = traffic_pkg::GREEN;
      StEwYellow: ew_light_d = traffic_pkg::YELLOW;
      StWalk:     walk_d     = 1'b1;
      StEmg: begin
        emg_act_d = 1'b1;
        if (emg_dir_d == DIR_NS) ns_light_d = traffic_pkg::GREEN;
        else                     ew_light_d = traffic_pkg::GREEN;
      end
      default: ;
    endcase
  end

  // State, request and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StAllRed;
      pend_ns_q  <= 1'b0;
      pend_ew_q  <= 1'b0;
      pend_ped_q <= 1'b0;
      last_dir_q <= DIR_EW;
      emg_dir_q  <= DIR_NS;
      served_q   <= 1'b0;
      ns_light_q <= traffic_pkg::RED;
      ew_light_q <= traffic_pkg::RED;
      walk_q     <= 1'b0;
      emg_act_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_ns_q  <= pend_ns_d;
      pend_ew_q  <= pend_ew_d;
      pend_ped_q <= pend_ped_d;
      last_dir_q <= last_dir_d;
      emg_dir_q  <= emg_dir_d;
      served_q   <= served_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      walk_q     <= walk_d;
      emg_act_q  <= emg_act_d;
    end
  end

  assign ns_light         = ns_light_q;
  assign ew_light         = ew_light_q;
  assign walk             = walk_q;
  assign emergency_active = emg_act_q;
  assign ped_pending      = pend_ped_q;

endmodule
